// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for a five-stage processor.
//               Operand forwarding, load-use stall, control-hazard flush and
//               a memory-wait freeze FSM (RUN / MEMWAIT / ERR) with a
//               timeout that latches a sticky memory error.
//               Optional build macro: HAZARD_PERF_EN adds the StallCycles
//               saturating performance counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  Ra1D,
   input  logic [3:0]  Ra2D,
   input  logic [3:0]  Ra1E,
   input  logic [3:0]  Ra2E,
   input  logic [3:0]  WA3E,
   input  logic [3:0]  WA3M,
   input  logic [3:0]  WA3W,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        MemtoRegE,
   input  logic        PCSrcD,
   input  logic        PCSrcE,
   input  logic        PCSrcM,
   input  logic        PCSrcW,
   input  logic        BranchTakenE,
   input  logic        MemReqM,
   input  logic        MemReadyM,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushD,
   output logic        FlushE,
   output logic        EnE,
   output logic        EnM,
   output logic        FlushW,
`ifdef HAZARD_PERF_EN
   output logic [31:0] StallCycles,
`endif
   output logic        MemErr
);

   // Index of the last frozen cycle before the timeout fires. The RUN cycle
   // that first sees the held-off access is frozen cycle 0.
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1,
      ST_ERR     = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        mem_err_q, mem_err_d;

   logic        ld_stall;
   logic        pc_pend;
   logic        mem_hold;
   logic        freeze;
   logic [7:0]  frozen_idx;

   // Operand forwarding: the younger result in Memory beats the one in Writeback.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (RegWriteM && (Ra1E == WA3M))      ForwardAE = 2'b10;
      else if (RegWriteW && (Ra1E == WA3W)) ForwardAE = 2'b01;
      if (RegWriteM && (Ra2E == WA3M))      ForwardBE = 2'b10;
      else if (RegWriteW && (Ra2E == WA3W)) ForwardBE = 2'b01;
   end

   // Hazard causes and the freeze condition (current state plus live memory handshake).
   always_comb begin
      ld_stall   = MemtoRegE && ((WA3E == Ra1D) || (WA3E == Ra2D));
      pc_pend    = PCSrcD || PCSrcE || PCSrcM;
      mem_hold   = MemReqM && !MemReadyM;
      // MEMWAIT counts frozen cycles from 1; the counter holds the previous index.
      frozen_idx = wait_cnt_q + 8'd1;
      freeze     = 1'b0;
      case (state_q)
         ST_RUN:     freeze = mem_hold;
         ST_MEMWAIT: freeze = !MemReadyM;
         ST_ERR:     freeze = 1'b1;
         default:    freeze = 1'b1;
      endcase
   end

   // Pipeline control outputs; the freeze masks every stall and flush cause.
   always_comb begin
      StallF = ld_stall || pc_pend;
      StallD = ld_stall;
      FlushD = pc_pend || PCSrcW || BranchTakenE;
      FlushE = ld_stall || BranchTakenE;
      EnE    = 1'b1;
      EnM    = 1'b1;
      FlushW = 1'b0;
      if (freeze) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushD = 1'b0;
         FlushE = 1'b0;
         EnE    = 1'b0;
         EnM    = 1'b0;
         FlushW = 1'b1;
      end
   end

   // Wait-state FSM next state; a ready in MEMWAIT wins over the timeout.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      case (state_q)
         ST_RUN: begin
            if (mem_hold) begin
               state_d    = ST_MEMWAIT;
               wait_cnt_d = 8'd0;
            end
         end
         ST_MEMWAIT: begin
            if (MemReadyM) begin
               state_d    = ST_RUN;
               wait_cnt_d = 8'd0;
            end else if (frozen_idx == TIMEOUT_LAST) begin
               state_d    = ST_ERR;
               mem_err_d  = 1'b1;
            end else begin
               wait_cnt_d = frozen_idx;
            end
         end
         ST_ERR: begin
            state_d   = ST_ERR;
            mem_err_d = 1'b1;
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   // FSM state, wait counter and sticky error flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= 8'd0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   assign MemErr = mem_err_q;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;

   // Saturating count of cycles in which the fetch stage is held.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (StallF && (stall_cycles_q != 32'hFFFF_FFFF))
         stall_cycles_d = stall_cycles_q + 32'd1;
   end

   // Performance counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_cycles_q <= 32'd0;
      else        stall_cycles_q <= stall_cycles_d;
   end

   assign StallCycles = stall_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W;
   logic       RegWriteM, RegWriteW, MemtoRegE;
   logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
   logic       MemReqM, MemReadyM;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, FlushD, FlushE, EnE, EnM, FlushW, MemErr;
`ifdef HAZARD_PERF_EN
   logic [31:0] StallCycles;
`endif

   int checks = 0;
   int errors = 0;

   logic [11:0] exp_q[$];
   string       tag_q[$];

   hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .Ra1D        (Ra1D),
      .Ra2D        (Ra2D),
      .Ra1E        (Ra1E),
      .Ra2E        (Ra2E),
      .WA3E        (WA3E),
      .WA3M        (WA3M),
      .WA3W        (WA3W),
      .RegWriteM   (RegWriteM),
      .RegWriteW   (RegWriteW),
      .MemtoRegE   (MemtoRegE),
      .PCSrcD      (PCSrcD),
      .PCSrcE      (PCSrcE),
      .PCSrcM      (PCSrcM),
      .PCSrcW      (PCSrcW),
      .BranchTakenE(BranchTakenE),
      .MemReqM     (MemReqM),
      .MemReadyM   (MemReadyM),
      .ForwardAE   (ForwardAE),
      .ForwardBE   (ForwardBE),
      .StallF      (StallF),
      .StallD      (StallD),
      .FlushD      (FlushD),
      .FlushE      (FlushE),
      .EnE         (EnE),
      .EnM         (EnM),
      .FlushW      (FlushW),
`ifdef HAZARD_PERF_EN
      .StallCycles (StallCycles),
`endif
      .MemErr      (MemErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

   // Expected output vector: {FwdA, FwdB, StallF, StallD, FlushD, FlushE, EnE, EnM, FlushW, MemErr}
   function automatic logic [11:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                      input logic sf, input logic sd, input logic fd,
                                      input logic fe, input logic ene, input logic enm,
                                      input logic fw, input logic me);
      return {fa, fb, sf, sd, fd, fe, ene, enm, fw, me};
   endfunction

   task automatic clr_inputs();
      Ra1D = 4'd0; Ra2D = 4'd0; Ra1E = 4'd0; Ra2E = 4'd0;
      WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
      RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
      PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
      BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
   endtask

   // Push the expectation for the cycle just driven, sample at the falling edge,
   // pop and compare, then advance to just after the next rising edge.
   task automatic step(input string tag, input logic [11:0] exp);
      logic [11:0] obs;
      logic [11:0] want;
      string       t;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clk);
      obs  = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, EnE, EnM, FlushW, MemErr};
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", t, obs, want);
      end
      @(posedge clk);
      #1;
   endtask

   localparam logic [11:0] IDLE   = 12'b00_00_0000_1100;
   localparam logic [11:0] FREEZE = 12'b00_00_1100_0010;
   localparam logic [11:0] ERRFRZ = 12'b00_00_1100_0011;

   initial begin
      clr_inputs();
      reset = 1'b0;
      step("reset_state", IDLE);
      reset = 1'b1;

      // Forwarding
      RegWriteM = 1'b1; WA3M = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3; Ra1E = 4'd3; Ra2E = 4'd5;
      step("fwd_m_priority", mk(2'b10, 2'b00, 0,0,0,0,1,1,0,0));
      RegWriteM = 1'b0;
      step("fwd_w_only", mk(2'b01, 2'b00, 0,0,0,0,1,1,0,0));
      RegWriteM = 1'b1; WA3M = 4'd5;
      step("fwd_a_w_b_m", mk(2'b01, 2'b10, 0,0,0,0,1,1,0,0));
      clr_inputs();

      // Load-use stall on Ra2D, then load in M forwarding to the stalled consumer
      MemtoRegE = 1'b1; WA3E = 4'd2; Ra2D = 4'd2; Ra1D = 4'd9;
      step("ldstall_ra2", mk(2'b00, 2'b00, 1,1,0,1,1,1,0,0));
      MemtoRegE = 1'b0; RegWriteM = 1'b1; WA3M = 4'd2; Ra2E = 4'd2; Ra1E = 4'd9;
      step("ldstall_release", mk(2'b00, 2'b10, 0,0,0,0,1,1,0,0));
      clr_inputs();
      MemtoRegE = 1'b1; WA3E = 4'd7; Ra1D = 4'd7; Ra2D = 4'd1;
      step("ldstall_ra1", mk(2'b00, 2'b00, 1,1,0,1,1,1,0,0));
      clr_inputs();

      // Control hazards
      BranchTakenE = 1'b1;
      step("branch_taken", mk(2'b00, 2'b00, 0,0,1,1,1,1,0,0));
      BranchTakenE = 1'b0; PCSrcD = 1'b1;
      step("pcsrc_d", mk(2'b00, 2'b00, 1,0,1,0,1,1,0,0));
      PCSrcD = 1'b0; PCSrcW = 1'b1;
      step("pcsrc_w", mk(2'b00, 2'b00, 0,0,1,0,1,1,0,0));
      clr_inputs();

      // Memory wait of 3 cycles with a simultaneous load-use hazard
      MemReqM = 1'b1; MemtoRegE = 1'b1; WA3E = 4'd2; Ra2D = 4'd2;
      step("memwait_c0", FREEZE);
      RegWriteW = 1'b1; WA3W = 4'd3; Ra1E = 4'd3;
      step("memwait_c1_fwd", mk(2'b01, 2'b00, 1,1,0,0,0,0,1,0));
      RegWriteW = 1'b0; BranchTakenE = 1'b1;
      step("memwait_c2_masked", FREEZE);
      BranchTakenE = 1'b0; MemReadyM = 1'b1;
      step("memwait_release", mk(2'b00, 2'b00, 1,1,0,1,1,1,0,0));
      clr_inputs();
      step("memwait_back_run", IDLE);

      // Timeout: ready never asserted, ERR after the 4th frozen edge
      MemReqM = 1'b1;
      step("tmo_c0", FREEZE);
      step("tmo_c1", FREEZE);
      step("tmo_c2", FREEZE);
      step("tmo_c3", FREEZE);
      step("tmo_err", ERRFRZ);
      MemReqM = 1'b0; MemReadyM = 1'b1; PCSrcD = 1'b1;
      step("err_sticky", ERRFRZ);
      clr_inputs();
      reset = 1'b0;
      step("err_async_reset", IDLE);
      reset = 1'b1;
      step("after_reset_run", IDLE);

      // Ready on frozen cycle 3 beats the timeout
      MemReqM = 1'b1;
      step("late_c0", FREEZE);
      step("late_c1", FREEZE);
      step("late_c2", FREEZE);
      MemReadyM = 1'b1;
      step("late_ready_c3", IDLE);
      clr_inputs();
      step("late_no_err", IDLE);

`ifdef HAZARD_PERF_EN
      // Fresh counter: 1 load-use stall plus 3 frozen cycles
      reset = 1'b0;
      step("perf_reset", IDLE);
      reset = 1'b1;
      checks++;
      assert (StallCycles === 32'd0) else begin
         errors++;
         $error("FAIL perf_zero: observed %0d expected 0", StallCycles);
      end
      MemtoRegE = 1'b1; WA3E = 4'd4; Ra1D = 4'd4;
      step("perf_ld", mk(2'b00, 2'b00, 1,1,0,1,1,1,0,0));
      clr_inputs();
      MemReqM = 1'b1;
      step("perf_w0", FREEZE);
      step("perf_w1", FREEZE);
      step("perf_w2", FREEZE);
      MemReadyM = 1'b1;
      step("perf_rel", IDLE);
      clr_inputs();
      step("perf_idle", IDLE);
      checks++;
      assert (StallCycles === 32'd4) else begin
         errors++;
         $error("FAIL perf_count: observed %0d expected 4", StallCycles);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
